// File: rtl/edge_event_arbiter_if.sv
// Event port between edge_event_arbiter and its single downstream consumer.
//
// Signals:
//   event_valid    arbiter -> consumer  an event is offered
//   event_ready    consumer -> arbiter  consumer accepts the offered event
//   event_channel  arbiter -> consumer  channel index of the offered event
//   event_falling  arbiter -> consumer  offered event is a falling edge
//                                       (only with EDGE_EVENT_ARBITER_FALLING_EN)
//
// Modports: master = arbiter side, slave = consumer side.
// Configuration macro: EDGE_EVENT_ARBITER_FALLING_EN adds event_falling.

interface edge_event_arbiter_if #(
  parameter int CHANNELS = 4
);
  localparam int INDEX_WIDTH = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic                   event_valid;
  logic                   event_ready;
  logic [INDEX_WIDTH-1:0] event_channel;
`ifdef EDGE_EVENT_ARBITER_FALLING_EN
  logic                   event_falling;
`endif

  modport master (
    input  event_ready,
    output event_valid,
    output event_channel
`ifdef EDGE_EVENT_ARBITER_FALLING_EN
    ,
    output event_falling
`endif
  );

  modport slave (
    output event_ready,
    input  event_valid,
    input  event_channel
`ifdef EDGE_EVENT_ARBITER_FALLING_EN
    ,
    input  event_falling
`endif
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: captures rising edges on CHANNELS level signals as
// per-channel pending events and serves them round-robin, one per transfer,
// through a single valid/ready event port.
//
// Ports:
//   clock           in   single clock, all state on rising edge
//   reset           in   asynchronous, active-high reset
//   signals         in   [CHANNELS] monitored levels, synchronous to clock
//   evt             if   master side of edge_event_arbiter_if
//                        (event_valid, event_ready, event_channel[, event_falling])
//   pending         out  [CHANNELS] per-channel pending event bits
//   overflow        out  [CHANNELS] sticky: edge seen while channel already pending
//   overflow_clear  in   [CHANNELS] per-bit clear of overflow (a new overflow wins)
//
// Configuration macro: EDGE_EVENT_ARBITER_FALLING_EN
//   When defined, falling edges are captured in a second pending vector and
//   offered with event_falling=1; per channel the rising event goes first.
//   When undefined, falling edges are ignored.

module edge_event_arbiter #(
  parameter int CHANNELS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] signals,
  edge_event_arbiter_if.master evt,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] overflow,
  input  logic [CHANNELS-1:0] overflow_clear
);
  localparam int INDEX_WIDTH = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  // Registered state
  logic [CHANNELS-1:0]    previous;
  logic [CHANNELS-1:0]    pend_rise;
  logic [CHANNELS-1:0]    overflow_q;
  logic                   valid_q;
  logic [INDEX_WIDTH-1:0] channel_q;
  logic [INDEX_WIDTH-1:0] pointer;

  // Combinational next-state
  logic [CHANNELS-1:0]    rise;
  logic [CHANNELS-1:0]    clr_rise;
  logic [CHANNELS-1:0]    pend_rise_next;
  logic [CHANNELS-1:0]    ovf_set;
  logic [CHANNELS-1:0]    overflow_next;
  logic [CHANNELS-1:0]    cand;
  logic                   transfer;
  logic                   found;
  logic [INDEX_WIDTH-1:0] sel;
  logic [INDEX_WIDTH-1:0] next_ptr;
  logic [INDEX_WIDTH:0]   slot;

`ifdef EDGE_EVENT_ARBITER_FALLING_EN
  logic                   falling_q;
  logic [CHANNELS-1:0]    pend_fall;
  logic [CHANNELS-1:0]    fall;
  logic [CHANNELS-1:0]    clr_fall;
  logic [CHANNELS-1:0]    pend_fall_next;
  logic                   sel_fall;
`endif

  always_comb begin
    rise     = signals & ~previous;
    transfer = valid_q & evt.event_ready;
    clr_rise = '0;
`ifdef EDGE_EVENT_ARBITER_FALLING_EN
    fall     = ~signals & previous;
    clr_fall = '0;
    if (transfer) begin
      if (falling_q) clr_fall[channel_q] = 1'b1;
      else           clr_rise[channel_q] = 1'b1;
    end
`else
    if (transfer) clr_rise[channel_q] = 1'b1;
`endif

    // Clear of the transferred bit and a new edge in the same cycle: the
    // edge wins and is not an overflow, since the old event just left.
    pend_rise_next = (pend_rise & ~clr_rise) | rise;
    ovf_set        = rise & pend_rise & ~clr_rise;
`ifdef EDGE_EVENT_ARBITER_FALLING_EN
    pend_fall_next = (pend_fall & ~clr_fall) | fall;
    ovf_set        = ovf_set | (fall & pend_fall & ~clr_fall);
`endif
    overflow_next = (overflow_q & ~overflow_clear) | ovf_set;

    // Candidates are the registered pending bits only: an edge seen this
    // cycle becomes offerable one clock later. The channel being
    // transferred is excluded so it cannot be reoffered back-to-back.
`ifdef EDGE_EVENT_ARBITER_FALLING_EN
    cand = pend_rise | pend_fall;
`else
    cand = pend_rise;
`endif
    if (transfer) cand[channel_q] = 1'b0;

    // First candidate at/after pointer, wrapping CHANNELS-1 -> 0.
    found = 1'b0;
    sel   = '0;
    slot  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      slot = {1'b0, pointer} + (INDEX_WIDTH+1)'(i);
      if (slot >= (INDEX_WIDTH+1)'(CHANNELS))
        slot = slot - (INDEX_WIDTH+1)'(CHANNELS);
      if (!found && cand[slot[INDEX_WIDTH-1:0]]) begin
        found = 1'b1;
        sel   = slot[INDEX_WIDTH-1:0];
      end
    end
`ifdef EDGE_EVENT_ARBITER_FALLING_EN
    sel_fall = ~pend_rise[sel];
`endif

    if (channel_q == INDEX_WIDTH'(CHANNELS - 1)) next_ptr = '0;
    else                                         next_ptr = channel_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      previous   <= '0;
      pend_rise  <= '0;
      overflow_q <= '0;
      valid_q    <= 1'b0;
      channel_q  <= '0;
      pointer    <= '0;
`ifdef EDGE_EVENT_ARBITER_FALLING_EN
      pend_fall  <= '0;
      falling_q  <= 1'b0;
`endif
    end else begin
      previous   <= signals;
      pend_rise  <= pend_rise_next;
      overflow_q <= overflow_next;
`ifdef EDGE_EVENT_ARBITER_FALLING_EN
      pend_fall  <= pend_fall_next;
`endif
      if (transfer) pointer <= next_ptr;
      // An outstanding offer is only replaced after it transfers.
      if (!valid_q || transfer) begin
        valid_q <= found;
        if (found) begin
          channel_q <= sel;
`ifdef EDGE_EVENT_ARBITER_FALLING_EN
          falling_q <= sel_fall;
`endif
        end
      end
    end
  end

  assign evt.event_valid   = valid_q;
  assign evt.event_channel = channel_q;
`ifdef EDGE_EVENT_ARBITER_FALLING_EN
  assign evt.event_falling = falling_q;
  assign pending           = pend_rise | pend_fall;
`else
  assign pending           = pend_rise;
`endif
  assign overflow          = overflow_q;

endmodule
